// File: rtl/down_result_reader.sv
// Reads a row range from the systolic array's down SRAM into a small FIFO and streams each row out on a store port.
// Define DOWN_RESULT_RELU_EN to clamp negative signed lanes to zero on o_st_data.
module down_result_reader #(
    parameter int NUM_COL              = 4,
    parameter int OUT_DATA_WIDTH       = 16,
    parameter int LOG2_SRAM_BANK_DEPTH = 6,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_end_addr,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_rd_addr,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0]   i_down_rd_data,
    output logic                                o_st_valid,
    input  logic                                i_st_ready,
    output logic [NUM_COL*OUT_DATA_WIDTH-1:0]   o_st_data,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_st_idx,
    output logic                                o_st_last
);

    localparam int W  = NUM_COL * OUT_DATA_WIDTH;
    localparam int AW = LOG2_SRAM_BANK_DEPTH;
    localparam int CW = AW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Read-issue side
    logic [AW-1:0] r_rd_addr;
    logic [CW-1:0] r_rd_left;
    logic [AW-1:0] w_span;
    logic          w_rd_en;
    logic          w_issue_last;
    logic          w_credit;

    // One read may be in flight; its address and last flag travel with it
    logic          r_outstanding;
    logic [AW-1:0] r_out_addr;
    logic          r_out_last;

    // Row FIFO
    logic [W-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_fifo_idx  [FIFO_DEPTH];
    logic          r_fifo_last [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [PW:0]   w_occ;
    logic [PW+1:0] w_level;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    logic [W-1:0]  w_head_raw;
    logic [W-1:0]  w_head_data;
    logic [AW-1:0] w_head_idx;
    logic          w_head_last;

    assign w_span       = i_end_addr - i_start_addr;
    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_empty      = (w_occ == '0);
    assign w_full       = (w_occ == (PW+1)'(FIFO_DEPTH));
    assign w_level      = {1'b0, w_occ} + {{(PW+1){1'b0}}, r_outstanding};
    // Counting the in-flight read against capacity means its return always has a slot
    assign w_credit     = (w_level < (PW+2)'(FIFO_DEPTH));
    assign w_rd_en      = (r_state == S_READ) && w_credit;
    assign w_issue_last = w_rd_en && (r_rd_left == CW'(1));
    assign w_push       = r_outstanding;
    assign w_pop        = !w_empty && i_st_ready;

    assign w_head_raw   = r_fifo_data[r_rd_ptr[PW-1:0]];
    assign w_head_idx   = r_fifo_idx[r_rd_ptr[PW-1:0]];
    assign w_head_last  = r_fifo_last[r_rd_ptr[PW-1:0]];

    always_comb begin
        w_head_data = w_head_raw;
`ifdef DOWN_RESULT_RELU_EN
        for (int l = 0; l < NUM_COL; l++) begin
            if (w_head_raw[l*OUT_DATA_WIDTH + OUT_DATA_WIDTH - 1]) begin
                w_head_data[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_READ;
            S_READ:  if (w_issue_last) w_next_state = S_FLUSH;
            S_FLUSH: if (w_pop && w_head_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr     <= '0;
            r_rd_left     <= '0;
            r_outstanding <= 1'b0;
            r_out_addr    <= '0;
            r_out_last    <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_rd_addr <= i_start_addr;
                r_rd_left <= {1'b0, w_span} + CW'(1);
            end else if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + AW'(1);
                r_rd_left <= r_rd_left - CW'(1);
            end
            r_outstanding <= w_rd_en;
            r_out_addr    <= r_rd_addr;
            r_out_last    <= w_issue_last;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr[PW-1:0]] <= i_down_rd_data;
            r_fifo_idx[r_wr_ptr[PW-1:0]]  <= r_out_addr;
            r_fifo_last[r_wr_ptr[PW-1:0]] <= r_out_last;
        end
    end

    // Store port: a beat moves when o_st_valid & i_st_ready; while valid and not ready the
    // beat (data/idx/last) is the unchanged FIFO head, and valid only falls after a transfer.
    assign o_st_valid     = !w_empty;
    assign o_st_data      = w_empty ? '0 : w_head_data;
    assign o_st_idx       = w_empty ? '0 : w_head_idx;
    assign o_st_last      = !w_empty && w_head_last;

    assign o_busy         = (r_state == S_READ) || (r_state == S_FLUSH);
    assign o_done         = (r_state == S_DONE);
    assign o_down_rd_en   = w_rd_en;
    assign o_down_rd_addr = w_rd_en ? r_rd_addr : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full));

    a_hold_stalled: assert property (@(posedge clk) disable iff (rst)
        (o_st_valid && !i_st_ready) |=>
        (o_st_valid && $stable(o_st_data) && $stable(o_st_idx) && $stable(o_st_last)));

    a_read_when_busy: assert property (@(posedge clk) disable iff (rst)
        o_down_rd_en |-> o_busy);

endmodule

// File: tb/tb_down_result_reader.sv
// Self-checking bench for down_result_reader: table of commands, hand-written reset/ReLU sequences, randomized commands.
module tb_down_result_reader;

    localparam int NC    = 4;
    localparam int OW    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int W     = NC * OW;
    localparam int BANK  = 64;
    localparam int GOTN  = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_start_addr = '0;
    logic [AW-1:0] i_end_addr = '0;
    logic          o_busy, o_done, o_down_rd_en;
    logic [AW-1:0] o_down_rd_addr;
    logic [W-1:0]  i_down_rd_data;
    logic          o_st_valid;
    logic          i_st_ready = 1'b1;
    logic [W-1:0]  o_st_data;
    logic [AW-1:0] o_st_idx;
    logic          o_st_last;

    always #5 clk = ~clk;

    down_result_reader #(
        .NUM_COL(NC), .OUT_DATA_WIDTH(OW), .LOG2_SRAM_BANK_DEPTH(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_start_addr(i_start_addr),
        .i_end_addr(i_end_addr), .o_busy(o_busy), .o_done(o_done),
        .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr),
        .i_down_rd_data(i_down_rd_data), .o_st_valid(o_st_valid), .i_st_ready(i_st_ready),
        .o_st_data(o_st_data), .o_st_idx(o_st_idx), .o_st_last(o_st_last)
    );

    // SRAM model: one-cycle read latency
    logic [W-1:0] mem [BANK];
    logic [W-1:0] sram_q = '0;
    always @(posedge clk) if (o_down_rd_en) sram_q <= mem[o_down_rd_addr];
    assign i_down_rd_data = sram_q;

    // Scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [W+AW:0] exp_q[$];

    // Monitor observations (written only by the monitor)
    int            cyc = 0;
    int            got_n = 0;
    logic [W-1:0]  got_data [GOTN];
    logic [AW-1:0] got_idx  [GOTN];
    logic          got_last [GOTN];
    int            got_cyc  [GOTN];
    int            done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int            busy_gap = 0, stab_viol = 0, credit_viol = 0;
    int            occ_m = 0, out_m = 0;
    logic          stall_prev = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic [AW-1:0] prev_idx = '0;
    logic          prev_last = 1'b0;

    // Driver-owned command context read by the monitor
    logic in_cmd = 1'b0;
    int   cmd_done_base = 0;

    always @(negedge clk) begin
        logic hs;
        cyc = cyc + 1;
        if (o_down_rd_en && (occ_m + out_m >= DEPTH)) credit_viol = credit_viol + 1;
        if (stall_prev && !(o_st_valid && o_st_data == prev_data &&
                            o_st_idx == prev_idx && o_st_last == prev_last))
            stab_viol = stab_viol + 1;
        hs = o_st_valid && i_st_ready && !rst;
        if (hs) begin
            if (got_n < GOTN) begin
                got_data[got_n] = o_st_data;
                got_idx[got_n]  = o_st_idx;
                got_last[got_n] = o_st_last;
                got_cyc[got_n]  = cyc;
            end
            got_n = got_n + 1;
            if (o_st_last) last_hs_cyc = cyc;
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            if (o_busy) busy_gap = busy_gap + 1;
        end
        if (in_cmd && done_cnt == cmd_done_base && !o_busy) busy_gap = busy_gap + 1;
        stall_prev = o_st_valid && !i_st_ready && !rst;
        prev_data  = o_st_data;
        prev_idx   = o_st_idx;
        prev_last  = o_st_last;
        if (rst) begin
            occ_m = 0;
            out_m = 0;
        end else begin
            occ_m = occ_m + out_m - (hs ? 1 : 0);
            out_m = o_down_rd_en ? 1 : 0;
        end
    end

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            mode;       // 0: ready high, 1: ready 1-of-3, 2: random ready
        int            inj;        // cycle at which a stray start is pulsed, -1 for none
        int            exp_n;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_final;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] relu_ref(input logic [W-1:0] row);
        logic [W-1:0] r;
        r = row;
`ifdef DOWN_RESULT_RELU_EN
        for (int l = 0; l < NC; l++) begin
            int v;
            v = int'(row[l*OW +: OW]);
            if (v >= 32768) v = v - 65536;
            if (v < 0) r[l*OW +: OW] = '0;
        end
`endif
        return r;
    endfunction

    task automatic push_expected(input logic [AW-1:0] s, input logic [AW-1:0] e);
        int n;
        n = ((int'(e) - int'(s) + BANK) % BANK) + 1;
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] idx;
            idx = AW'((int'(s) + k) % BANK);
            exp_q.push_back({(k == n - 1), idx, relu_ref(mem[idx])});
        end
    endtask

    task automatic set_ready(input int mode, input int k);
        if (mode == 0)      i_st_ready = 1'b1;
        else if (mode == 1) i_st_ready = ((k % 3) == 0);
        else                i_st_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_cmd(input vec_t v);
        int base, dbase, sv, cv, bg, nb;
        logic finished;
        base = got_n; dbase = done_cnt; sv = stab_viol; cv = credit_viol; bg = busy_gap;
        cmd_done_base = dbase;
        push_expected(v.s, v.e);
        i_start = 1'b1; i_start_addr = v.s; i_end_addr = v.e;
        set_ready(v.mode, 0);
        tick();
        i_start = 1'b0;
        in_cmd = 1'b1;
        finished = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            set_ready(v.mode, k);
            if (k == v.inj) begin
                i_start = 1'b1; i_start_addr = 6'd20; i_end_addr = 6'd25;
            end else begin
                i_start = 1'b0;
            end
            tick();
            if (done_cnt != dbase) begin
                finished = 1'b1;
                break;
            end
        end
        i_start = 1'b0;
        in_cmd = 1'b0;
        i_st_ready = 1'b1;
        repeat (6) tick();
        check("done_seen", finished, 1'b1);
        nb = got_n - base;
        check("beat_count", nb, v.exp_n);
        for (int j = 0; j < nb && j < GOTN - base; j++) begin
            logic [W+AW:0] exp;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("beat", {got_last[base+j], got_idx[base+j], got_data[base+j]}, exp);
        end
        check("exp_left", exp_q.size(), 0);
        exp_q.delete();
        if (nb > 0) begin
            check("first_idx", got_idx[base], v.exp_first);
            check("final_idx", got_idx[got_n-1], v.exp_final);
            if (v.mode == 0) check("throughput", got_cyc[got_n-1] - got_cyc[base], nb - 1);
        end
        check("done_pulses", done_cnt - dbase, 1);
        check("done_timing", done_cyc, last_hs_cyc + 1);
        check("busy_window", busy_gap - bg, 0);
        check("hold_stalled", stab_viol - sv, 0);
        check("credit", credit_viol - cv, 0);
    endtask

    vec_t vecs[6];

    initial begin
        for (int i = 0; i < BANK; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[i] = 64'h0001_0002_0003_0004 + 64'(i);
        mem[40] = 64'h7FFF_8000_0005_FFFF;

        vecs[0] = '{s: 6'd0,  e: 6'd3, mode: 0, inj: -1, exp_n: 4, exp_first: 6'd0,  exp_final: 6'd3};
        vecs[1] = '{s: 6'd62, e: 6'd1, mode: 0, inj: -1, exp_n: 4, exp_first: 6'd62, exp_final: 6'd1};
        vecs[2] = '{s: 6'd5,  e: 6'd5, mode: 0, inj: -1, exp_n: 1, exp_first: 6'd5,  exp_final: 6'd5};
        vecs[3] = '{s: 6'd0,  e: 6'd7, mode: 1, inj: -1, exp_n: 8, exp_first: 6'd0,  exp_final: 6'd7};
        vecs[4] = '{s: 6'd0,  e: 6'd3, mode: 1, inj: 6,  exp_n: 4, exp_first: 6'd0,  exp_final: 6'd3};
        vecs[5] = '{s: 6'd60, e: 6'd2, mode: 2, inj: -1, exp_n: 7, exp_first: 6'd60, exp_final: 6'd2};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {o_busy, o_done, o_down_rd_en, o_down_rd_addr, o_st_valid, o_st_data, o_st_idx, o_st_last}, '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Reset in the middle of a command after two beats
        begin
            int base, dbase;
            base = got_n; dbase = done_cnt;
            push_expected(6'd0, 6'd7);
            i_start = 1'b1; i_start_addr = 6'd0; i_end_addr = 6'd7; i_st_ready = 1'b1;
            tick();
            i_start = 1'b0;
            for (int k = 0; k < 200; k++) begin
                tick();
                if (got_n - base >= 2) break;
            end
            rst = 1'b1;
            i_st_ready = 1'b0;
            check("rst_two_beats", got_n - base, 2);
            for (int j = 0; j < 2; j++)
                check("rst_beat", {got_last[base+j], got_idx[base+j], got_data[base+j]}, exp_q.pop_front());
            exp_q.delete();
            tick();
            check("rst_mid_outputs",
                  {o_busy, o_done, o_down_rd_en, o_down_rd_addr, o_st_valid, o_st_data, o_st_idx, o_st_last}, '0);
            rst = 1'b0;
            i_st_ready = 1'b1;
            repeat (8) tick();
            check("rst_no_done", done_cnt - dbase, 0);
            check("rst_no_late_beat", got_n - base, 2);
            run_cmd('{s: 6'd10, e: 6'd11, mode: 0, inj: -1, exp_n: 2, exp_first: 6'd10, exp_final: 6'd11});
        end

        // Lane clamp on a row with mixed-sign lanes
        run_cmd('{s: 6'd40, e: 6'd40, mode: 0, inj: -1, exp_n: 1, exp_first: 6'd40, exp_final: 6'd40});
`ifdef DOWN_RESULT_RELU_EN
        check("relu_row", got_data[got_n-1], 64'h7FFF_0000_0005_0000);
`else
        check("relu_row", got_data[got_n-1], 64'h7FFF_8000_0005_FFFF);
`endif

        // Randomized commands
        for (int r = 0; r < 12; r++) begin
            vec_t v;
            int len;
            v.s = AW'($urandom_range(0, BANK - 1));
            len = $urandom_range(0, 11);
            v.e = AW'((int'(v.s) + len) % BANK);
            v.mode = 2;
            v.inj = -1;
            v.exp_n = len + 1;
            v.exp_first = v.s;
            v.exp_final = v.e;
            run_cmd(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/down_result_reader.md
Name: down_result_reader

Overview:
- Reader side of the systolic array's output ("down") SRAM; the read-back end of the write path the array fills during DRAIN.
- On an ST command it issues `i_down_rd_en`/`i_down_rd_addr` reads over an address range and captures the returned rows into a small FIFO.
- It streams each row out on a valid/ready store port towards memory.
- Sits between the instruction decoder (command side) and `systolic_array_top` (SRAM side).

Parameters:
- NUM_COL, 4, number of array columns / lanes per row
- OUT_DATA_WIDTH, 16, bits per lane
- LOG2_SRAM_BANK_DEPTH, 6, address width of the down SRAM
- FIFO_DEPTH, 4, row-buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle command strobe
- i_start_addr  in  LOG2_SRAM_BANK_DEPTH  first row address, sampled with i_start
- i_end_addr  in  LOG2_SRAM_BANK_DEPTH  last row address (inclusive), sampled with i_start
- o_busy  out  1  high from accepted start until done pulse
- o_done  out  1  one-cycle pulse after final row accepted
- o_down_rd_en  out  1  SRAM read enable
- o_down_rd_addr  out  LOG2_SRAM_BANK_DEPTH  SRAM read address
- i_down_rd_data  in  NUM_COL*OUT_DATA_WIDTH  SRAM read data, valid 1 cycle after o_down_rd_en
- o_st_valid  out  1  store beat valid
- i_st_ready  in  1  store sink ready
- o_st_data  out  NUM_COL*OUT_DATA_WIDTH  row data, lane 0 in LSBs
- o_st_idx  out  LOG2_SRAM_BANK_DEPTH  SRAM address the beat came from
- o_st_last  out  1  marks final beat of the command

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0.
  - FSM to IDLE.
  - FIFO emptied; outstanding-read flag cleared.
  - Applies mid-operation: the in-flight command is abandoned, no done pulse, a pending SRAM return is discarded.
- FSM states: IDLE, READ, FLUSH, DONE.
  - IDLE→READ on i_start: latch start address, compute count = ((end−start) mod 2^LOG2_SRAM_BANK_DEPTH)+1; o_busy=1 from the next cycle.
  - READ: issue one read per cycle while credit exists. Credit = FIFO occupancy + outstanding read < FIFO_DEPTH. Address increments mod 2^LOG2_SRAM_BANK_DEPTH (wrap 63→0). After the count-th read issued → FLUSH.
  - FLUSH: no reads. When the last beat (o_st_last) handshakes → DONE.
  - DONE: o_done=1 for one cycle, o_busy drops same cycle, → IDLE.
- i_start while not IDLE: ignored, no effect.
- end==start: exactly one row. end<start: wraps through the top of the bank, e.g. start=62, end=1 → 4 rows 62,63,0,1.
- Read latency: rd_data captured into FIFO on the edge after rd_en. o_st_valid may assert the cycle after capture; minimum start→first valid = 3 cycles.
- Store handshake:
  - Beat transfers when o_st_valid & i_st_ready.
  - o_st_data/o_st_idx/o_st_last hold stable while valid & !ready.
  - Valid never deasserts without a transfer.
- Simultaneous FIFO push and pop is allowed; occupancy unchanged.
- Credit rule guarantees no FIFO overflow; with i_st_ready held high, throughput is 1 row/cycle.
- o_st_last asserts only on the count-th beat.

Optional Feature:
- Macro DOWN_RESULT_RELU_EN.
- Defined: each OUT_DATA_WIDTH lane is treated as signed two's complement; negative lanes are replaced by 0 on o_st_data. Applied at FIFO output, no extra latency.
- Undefined: data passes bit-exact.

Test Plan:
- Basic read: SRAM rows 0..3 preloaded 0x0001_0002_0003_0004+row; start=0, end=3, ready=1 → 4 beats idx 0,1,2,3 on consecutive cycles, last on idx 3, o_done one cycle after, o_busy 1 throughout.
- Wrap and single row: start=62, end=1 → beats idx 62,63,0,1. Then start=end=5 → exactly one beat, idx 5, last=1.
- Backpressure: start=0, end=7, i_st_ready toggled 1-of-3 cycles → data stable while stalled, no rd_en while occupancy+outstanding=4, all 8 rows in order.
- Reset mid-command: assert rst during READ with 2 beats delivered → next cycle all outputs 0, no o_done; a new start=10, end=11 delivers exactly idx 10,11.
- Ignored start: pulse i_start (start=20) while busy on 0..3 → only rows 0..3 delivered, single o_done.
- RELU (macro defined): row lanes 0xFFFF,0x0005,0x8000,0x7FFF → o_st_data lanes 0x0000,0x0005,0x0000,0x7FFF; undefined → unchanged.
